serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: d = a - b - bin, one bit per clock, LSB first.
//   A single full-subtractor cell and a borrow flip-flop replace a WIDTH-bit ripple chain.

---
 rtl/serial_sub_pkg.sv | 10 +
 rtl/serial_subtractor_full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 162 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - bi, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    // Pure combinational difference/borrow equations
    always_comb begin
        diff = x ^ y ^ bi;
        bo   = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, d = a - b - bin, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic cell_diff;
    logic cell_bo;
    logic accept;
    logic last_bit;

    full_subtractor u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bi   (borrow_q),
        .diff (cell_diff),
        .bo   (cell_bo)
    );

    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_LAST) state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from state
    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_DONE);
    end

    // Datapath next values: operand capture, serial shift, result latch
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            a_sr_d   = a;
            b_sr_d   = b;
            res_d    = '0;
            borrow_d = bin;
            cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_d  = a[WIDTH-1];
            b_msb_d  = b[WIDTH-1];
`endif
        end else if (state_q == ST_SHIFT) begin
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            res_d    = {cell_diff, res_q[WIDTH-1:1]};
            borrow_d = cell_bo;
            if (last_bit) begin
                // Counter wraps here so it never exceeds WIDTH-1
                cnt_d  = '0;
                d_d    = {cell_diff, res_q[WIDTH-1:1]};
                bout_d = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d  = (a_msb_q ^ b_msb_q) & (cell_diff ^ a_msb_q);
`endif
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8); covers SERIAL_SUB_OVF_EN when defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf_s),
`endif
        .bout  (bout)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf_s = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_d;
        logic         exp_bout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE or DONE. Returns the number of
    // negedges from the accepting edge to done, and how many of them had busy.
    // When glitch is set, start is pulsed with junk operands during SHIFT.
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                      input bit glitch, output int done_cyc, output int busy_cyc);
        done_cyc = 0;
        busy_cyc = 0;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            a = $urandom; b = $urandom; bin = $urandom_range(0, 1);
            if (glitch && (c == 2 || c == 3 || c == 6)) start = 1'b1;
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        if (done_cyc == 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ed, input logic eb,
                                input logic eo);
        check({tag, "_d"}, 32'(d), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf_s), 32'(eo));
`else
        if (eo === 1'bx) check({tag, "_ovf_x"}, 0, 1);
`endif
    endtask

    initial begin
        int dc, bc;
        logic [W:0] ref9;
        logic       ref_ovf;
        logic [W-1:0] ra, rb;
        logic       rbin;
        int         saw_done;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check_result("rst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Latency and occupancy of a single operation
        op(8'h05, 8'h03, 1'b0, 1'b0, dc, bc);
        check("lat_busy_cycles", 32'(bc), 8);
        check("lat_done_cycle", 32'(dc), 9);
        check_result("t1", 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 0);

        // Table of directed vectors
        foreach (vecs[i]) begin
            op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, dc, bc);
            check_result($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_bout, vecs[i].exp_ovf);
            @(negedge clk);
        end

        // Back-to-back: start issued while in DONE
        op(8'h05, 8'h03, 1'b0, 1'b0, dc, bc);
        op(8'hFF, 8'h01, 1'b0, 1'b0, dc, bc);
        check("b2b_spacing", 32'(dc), 9);
        check_result("b2b", 8'hFE, 1'b0, 1'b0);
        // Result holds after done drops
        @(negedge clk);
        @(negedge clk);
        check_result("hold", 8'hFE, 1'b0, 1'b0);

        // start pulses during SHIFT must be ignored
        op(8'h10, 8'h01, 1'b0, 1'b1, dc, bc);
        check("glitch_done_cycle", 32'(dc), 9);
        check_result("glitch", 8'h0F, 1'b0, 1'b0);
        @(negedge clk);
        check("glitch_no_requeue", 32'(busy), 0);

        // Reset in the middle of SHIFT aborts the operation
        a = 8'h03; b = 8'h05; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check_result("midrst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("no_done_after_rst", 32'(saw_done), 0);
        op(8'h80, 8'h01, 1'b0, 1'b0, dc, bc);
        check_result("after_rst", 8'h7F, 1'b0, 1'b1);
        @(negedge clk);

        // Random operands against the arithmetic reference
        for (int k = 0; k < 60; k++) begin
            ra = $urandom; rb = $urandom; rbin = $urandom_range(0, 1);
            ref9 = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            ref_ovf = (ra[W-1] != rb[W-1]) && (ref9[W-1] != ra[W-1]);
            op(ra, rb, rbin, 1'b0, dc, bc);
            check_result($sformatf("rnd%0d", k), ref9[W-1:0], ref9[W], ref_ovf);
            if (k % 3 == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
